// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the decode-to-execute boundary: controller
// states, the D_E register bundle and its bubble value.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    REDIRECT = 2'd2
  } de_state_e;

  typedef struct packed {
    logic [4:0] rs1_adr;
    logic [4:0] rs2_adr;
    logic [4:0] rd_adr;
    logic       rd_en;
    logic       load_en;
    logic       uj_en;
    logic       jalr_en;
    logic       u_en;
    logic       auipc_en;
    logic       valid;
  } de_bundle_t;

  // A bubble is an all-zero bundle: invalid, no write-back, no load.
  localparam de_bundle_t DE_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the instruction in D reads a
// register that the load currently in E has not yet produced.
module load_use_detect (
  input  logic       i_d_valid,
  input  logic [4:0] i_rs1_adr,
  input  logic       i_rs1_used,
  input  logic [4:0] i_rs2_adr,
  input  logic       i_rs2_used,
  input  logic       i_de_valid,
  input  logic       i_de_load_en,
  input  logic       i_de_rd_en,
  input  logic [4:0] i_de_rd_adr,
  output logic       o_lu
);

  logic w_load_in_e;
  logic w_src_match;

  // x0 is never written, so a load targeting it cannot create a hazard.
  always_comb begin
    w_load_in_e = i_d_valid && i_de_valid && i_de_load_en && i_de_rd_en &&
                  (i_de_rd_adr != 5'd0);
    w_src_match = (i_rs1_used && (i_rs1_adr == i_de_rd_adr)) ||
                  (i_rs2_used && (i_rs2_adr == i_de_rd_adr));
    o_lu        = w_load_in_e && w_src_match;
  end

endmodule

// File: rtl/de_stage_ctrl.sv
// Decode-to-execute stage controller: D_E pipeline register, load-use
// stall / redirect flush FSM and saturating stall/flush event counters.
module de_stage_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [4:0]       rs1_adr,
  input  logic [4:0]       rs2_adr,
  input  logic [4:0]       rd_adr,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             rd_en,
  input  logic             load_en,
  input  logic             UJ_en,
  input  logic             jalr_en,
  input  logic             U_en,
  input  logic             auipc_en,
  input  logic             redirect,
  input  logic             mem_stall,
  output logic [4:0]       D_E_rs1_adr,
  output logic [4:0]       D_E_rs2_adr,
  output logic [4:0]       D_E_rd_adr,
  output logic             D_E_rd_en,
  output logic             D_E_load_en,
  output logic             D_E_UJ_en,
  output logic             D_E_jalr_en,
  output logic             D_E_U_en,
  output logic             D_E_auipc_en,
  output logic             D_E_valid,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_FD,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  de_state_e        r_state;
  de_state_e        w_state_nxt;
  de_bundle_t       r_de;
  de_bundle_t       w_de_in;
  logic             w_lu;
  logic             w_flush_act;
  logic             w_stall_act;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  load_use_detect u_lu (
    .i_d_valid    (d_valid),
    .i_rs1_adr    (rs1_adr),
    .i_rs1_used   (rs1_used),
    .i_rs2_adr    (rs2_adr),
    .i_rs2_used   (rs2_used),
    .i_de_valid   (r_de.valid),
    .i_de_load_en (r_de.load_en),
    .i_de_rd_en   (r_de.rd_en),
    .i_de_rd_adr  (r_de.rd_adr),
    .o_lu         (w_lu)
  );

  // Pack the D-stage fields and resolve which event this cycle acts on
  // (mem_stall > redirect/REDIRECT > load-use).
  always_comb begin
    w_de_in.rs1_adr  = rs1_adr;
    w_de_in.rs2_adr  = rs2_adr;
    w_de_in.rd_adr   = rd_adr;
    w_de_in.rd_en    = rd_en;
    w_de_in.load_en  = load_en;
    w_de_in.uj_en    = UJ_en;
    w_de_in.jalr_en  = jalr_en;
    w_de_in.u_en     = U_en;
    w_de_in.auipc_en = auipc_en;
    w_de_in.valid    = d_valid;
    w_flush_act = !mem_stall && (redirect || (r_state == REDIRECT));
    w_stall_act = !mem_stall && !redirect && (r_state != REDIRECT) && w_lu;
  end

  // State register; reset drops any pending REDIRECT immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a frozen pipe keeps its state.
  always_comb begin
    w_state_nxt = r_state;
    if (mem_stall)              w_state_nxt = r_state;
    else if (redirect)          w_state_nxt = REDIRECT;
    else if (r_state == REDIRECT) w_state_nxt = RUN;
    else if (w_lu)              w_state_nxt = LD_STALL;
    else                        w_state_nxt = RUN;
  end

  // Fetch/decode controls; forced low while reset is held.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    flush_FD = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
      end else if (w_flush_act) begin
        flush_FD = 1'b1;
      end else if (w_stall_act) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
      end
    end
  end

  // D_E register: hold on mem_stall, bubble on flush or load-use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_de <= DE_BUBBLE;
    else if (!mem_stall) begin
      if (w_flush_act || w_stall_act)   r_de <= DE_BUBBLE;
      else                              r_de <= w_de_in;
    end
  end

  // Event counters: one count per bubble / per flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_act) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush_act) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign D_E_rs1_adr  = r_de.rs1_adr;
  assign D_E_rs2_adr  = r_de.rs2_adr;
  assign D_E_rd_adr   = r_de.rd_adr;
  assign D_E_rd_en    = r_de.rd_en;
  assign D_E_load_en  = r_de.load_en;
  assign D_E_UJ_en    = r_de.uj_en;
  assign D_E_jalr_en  = r_de.jalr_en;
  assign D_E_U_en     = r_de.u_en;
  assign D_E_auipc_en = r_de.auipc_en;
  assign D_E_valid    = r_de.valid;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_de_stage_ctrl.sv
// Directed testbench for de_stage_ctrl.
module tb_de_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        d_valid, rs1_used, rs2_used;
  logic [4:0]  rs1_adr, rs2_adr, rd_adr;
  logic        rd_en, load_en, UJ_en, jalr_en, U_en, auipc_en;
  logic        redirect, mem_stall;
  logic [4:0]  D_E_rs1_adr, D_E_rs2_adr, D_E_rd_adr;
  logic        D_E_rd_en, D_E_load_en, D_E_UJ_en, D_E_jalr_en, D_E_U_en;
  logic        D_E_auipc_en, D_E_valid;
  logic        stall_F, stall_D, flush_FD;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  de_stage_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid),
    .rs1_adr(rs1_adr), .rs2_adr(rs2_adr), .rd_adr(rd_adr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_en(rd_en), .load_en(load_en), .UJ_en(UJ_en), .jalr_en(jalr_en),
    .U_en(U_en), .auipc_en(auipc_en),
    .redirect(redirect), .mem_stall(mem_stall),
    .D_E_rs1_adr(D_E_rs1_adr), .D_E_rs2_adr(D_E_rs2_adr),
    .D_E_rd_adr(D_E_rd_adr), .D_E_rd_en(D_E_rd_en),
    .D_E_load_en(D_E_load_en), .D_E_UJ_en(D_E_UJ_en),
    .D_E_jalr_en(D_E_jalr_en), .D_E_U_en(D_E_U_en),
    .D_E_auipc_en(D_E_auipc_en), .D_E_valid(D_E_valid),
    .stall_F(stall_F), .stall_D(stall_D), .flush_FD(flush_FD),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld);
    d_valid = v; rs1_adr = r1; rs1_used = u1; rs2_adr = r2; rs2_used = u2;
    rd_adr = rd; rd_en = we; load_en = ld;
    UJ_en = 1'b0; jalr_en = 1'b0; U_en = 1'b0; auipc_en = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; #2; rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    set_d(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b1);
    UJ_en = 1'b1; jalr_en = 1'b1; U_en = 1'b1; auipc_en = 1'b1;
    redirect = 1'b1; mem_stall = 1'b1;
    rst = 1'b1;
    tick(); tick();
    checks++; if ({stall_F, stall_D, flush_FD} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000", {stall_F, stall_D, flush_FD}); end
    checks++; if ({D_E_rs1_adr, D_E_rs2_adr, D_E_rd_adr, D_E_rd_en, D_E_load_en, D_E_UJ_en,
                   D_E_jalr_en, D_E_U_en, D_E_auipc_en, D_E_valid} !== 22'd0) begin
      failures++; $display("FAIL reset_de D_E_rd_adr=%0d D_E_valid=%b exp all zero", D_E_rd_adr, D_E_valid); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt); end
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    redirect = 1'b0; mem_stall = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if ({stall_F, stall_D, flush_FD} !== 3'b000) begin
      failures++; $display("FAIL reset_release_ctrl got=%b exp=000", {stall_F, stall_D, flush_FD}); end
    tick();
    checks++; if (flush_FD !== 1'b0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_state_run flush_FD=%b flush_cnt=%0d exp 0/0", flush_FD, flush_cnt); end
  endtask

  task automatic test_load_use_rs1();
    set_d(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd5, 1'b1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if ({stall_F, stall_D, flush_FD} !== 3'b110) begin
      failures++; $display("FAIL lu_rs1_stall got=%b exp=110", {stall_F, stall_D, flush_FD}); end
    tick();
    checks++; if (D_E_valid !== 1'b0 || D_E_rd_adr !== 5'd0 || D_E_load_en !== 1'b0) begin
      failures++; $display("FAIL lu_rs1_bubble valid=%b rd=%0d exp 0/0", D_E_valid, D_E_rd_adr); end
    checks++; if (stall_F !== 1'b0) begin
      failures++; $display("FAIL lu_rs1_release stall_F=%b exp=0", stall_F); end
    tick();
    checks++; if (D_E_valid !== 1'b1 || D_E_rd_adr !== 5'd6 || D_E_rs1_adr !== 5'd5 || D_E_load_en !== 1'b0) begin
      failures++; $display("FAIL lu_rs1_advance valid=%b rd=%0d rs1=%0d exp 1/6/5", D_E_valid, D_E_rd_adr, D_E_rs1_adr); end
    checks++; if (stall_cnt !== 32'd1) begin
      failures++; $display("FAIL lu_rs1_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_load_x0();
    set_d(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    checks++; if (stall_F !== 1'b0 || stall_D !== 1'b0) begin
      failures++; $display("FAIL load_x0_stall got=%b%b exp=00", stall_F, stall_D); end
    tick();
    checks++; if (stall_cnt !== 32'd1 || D_E_rd_adr !== 5'd7) begin
      failures++; $display("FAIL load_x0_cnt stall_cnt=%0d rd=%0d exp 1/7", stall_cnt, D_E_rd_adr); end
  endtask

  task automatic test_unused_operand();
    set_d(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (stall_F !== 1'b0) begin
      failures++; $display("FAIL unused_rs2 stall_F=%b exp=0", stall_F); end
    rs2_used = 1'b1;
    #1;
    checks++; if (stall_F !== 1'b1 || stall_D !== 1'b1) begin
      failures++; $display("FAIL used_rs2 stall=%b%b exp=11", stall_F, stall_D); end
    tick(); tick();
    checks++; if (stall_cnt !== 32'd2 || D_E_rd_adr !== 5'd8 || D_E_valid !== 1'b1) begin
      failures++; $display("FAIL used_rs2_cnt stall_cnt=%0d rd=%0d exp 2/8", stall_cnt, D_E_rd_adr); end
  endtask

  task automatic test_back_to_back();
    set_d(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    #1;
    checks++; if (stall_F !== 1'b1) begin
      failures++; $display("FAIL b2b_first_stall stall_F=%b exp=1", stall_F); end
    tick();
    tick();
    checks++; if (D_E_load_en !== 1'b1 || D_E_rd_adr !== 5'd6) begin
      failures++; $display("FAIL b2b_load_released load=%b rd=%0d exp 1/6", D_E_load_en, D_E_rd_adr); end
    set_d(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (stall_F !== 1'b1 || stall_D !== 1'b1) begin
      failures++; $display("FAIL b2b_second_stall got=%b%b exp=11", stall_F, stall_D); end
    tick(); tick();
    checks++; if (stall_cnt !== 32'd4 || D_E_rd_adr !== 5'd8) begin
      failures++; $display("FAIL b2b_cnt stall_cnt=%0d rd=%0d exp 4/8", stall_cnt, D_E_rd_adr); end
  endtask

  task automatic test_redirect_during_lu();
    pulse_rst();
    set_d(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    redirect = 1'b1;
    #1;
    checks++; if ({stall_F, stall_D, flush_FD} !== 3'b001) begin
      failures++; $display("FAIL redir_first got=%b exp=001", {stall_F, stall_D, flush_FD}); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (flush_FD !== 1'b1 || stall_F !== 1'b0 || D_E_valid !== 1'b0) begin
      failures++; $display("FAIL redir_second flush=%b stall=%b valid=%b exp 1/0/0", flush_FD, stall_F, D_E_valid); end
    tick();
    checks++; if (flush_FD !== 1'b0 || D_E_valid !== 1'b0) begin
      failures++; $display("FAIL redir_done flush=%b valid=%b exp 0/0", flush_FD, D_E_valid); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd2) begin
      failures++; $display("FAIL redir_cnt stall=%0d flush=%0d exp 0/2", stall_cnt, flush_cnt); end
    tick();
    checks++; if (D_E_valid !== 1'b1 || D_E_rd_adr !== 5'd6) begin
      failures++; $display("FAIL redir_resume valid=%b rd=%0d exp 1/6", D_E_valid, D_E_rd_adr); end
  endtask

  task automatic test_mem_stall_redirect();
    pulse_rst();
    set_d(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0);
    mem_stall = 1'b1; redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({stall_F, stall_D, flush_FD} !== 3'b110) begin
        failures++; $display("FAIL mstall_ctrl[%0d] got=%b exp=110", i, {stall_F, stall_D, flush_FD}); end
      tick();
      checks++; if (D_E_rd_adr !== 5'd9 || D_E_valid !== 1'b1 || flush_cnt !== 32'd0) begin
        failures++; $display("FAIL mstall_freeze[%0d] rd=%0d valid=%b flush_cnt=%0d exp 9/1/0", i, D_E_rd_adr, D_E_valid, flush_cnt); end
    end
    mem_stall = 1'b0;
    #1;
    checks++; if ({stall_F, stall_D, flush_FD} !== 3'b001) begin
      failures++; $display("FAIL mstall_release got=%b exp=001", {stall_F, stall_D, flush_FD}); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (flush_FD !== 1'b1 || D_E_valid !== 1'b0 || flush_cnt !== 32'd1) begin
      failures++; $display("FAIL mstall_redirect_state flush=%b valid=%b cnt=%0d exp 1/0/1", flush_FD, D_E_valid, flush_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (flush_FD !== 1'b0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL rst_mid_redirect flush=%b cnt=%0d exp 0/0", flush_FD, flush_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (flush_FD !== 1'b0 || stall_F !== 1'b0) begin
      failures++; $display("FAIL rst_mid_redirect_after flush=%b stall=%b exp 0/0", flush_FD, stall_F); end
    tick();
    checks++; if (flush_cnt !== 32'd0 || D_E_rd_adr !== 5'd12) begin
      failures++; $display("FAIL rst_no_residual flush_cnt=%0d rd=%0d exp 0/12", flush_cnt, D_E_rd_adr); end
  endtask

  initial begin
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    redirect = 1'b0; mem_stall = 1'b0;
    #3;
    test_reset();
    test_load_use_rs1();
    test_load_x0();
    test_unused_operand();
    test_back_to_back();
    test_redirect_during_lu();
    test_mem_stall_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
